// File: rtl/ctr_seq_pkg.sv
// Shared opcodes, state encoding and op-legality table for the counter sequencer.
package ctr_seq_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_NOP        = 3'd0;
  localparam logic [OP_W-1:0] OP_SET_PRE    = 3'd1;
  localparam logic [OP_W-1:0] OP_SET_LIM    = 3'd2;
  localparam logic [OP_W-1:0] OP_START_ONE  = 3'd3;
  localparam logic [OP_W-1:0] OP_START_AUTO = 3'd4;
  localparam logic [OP_W-1:0] OP_PAUSE      = 3'd5;
  localparam logic [OP_W-1:0] OP_RESUME     = 3'd6;
  localparam logic [OP_W-1:0] OP_ABORT      = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } ctr_state_t;

  // Which accepted opcodes take effect in each state; the rest raise cmd_err.
  function automatic logic op_legal(input ctr_state_t st, input logic [OP_W-1:0] op);
    logic ok;
    ok = 1'b0;
    case (st)
      ST_IDLE, ST_DONE: ok = (op != OP_PAUSE) && (op != OP_RESUME);
      ST_RUN:           ok = (op == OP_NOP) || (op == OP_PAUSE) || (op == OP_ABORT);
      ST_PAUSED:        ok = (op == OP_NOP) || (op == OP_RESUME) || (op == OP_ABORT);
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ctr_seq_prescaler.sv
// Prescale counter: counts while enabled, strobes tick_c when it matches pre_lim.
module ctr_seq_prescaler
  import ctr_seq_pkg::*;
#(
  parameter int unsigned PRE_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clear,
  input  logic [PRE_WIDTH-1:0] pre_lim,
  output logic                 tick_c
);

  logic [PRE_WIDTH-1:0] cnt;

  assign tick_c = en && (cnt == pre_lim);

  // clear has priority so an abort or start in the same cycle restarts the phase
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick_c ? '0 : cnt + PRE_WIDTH'(1);
    end
  end

endmodule

// File: rtl/ctr_sequencer.sv
// Command-driven sequencer for the prescaled up-counter.
// Optional sticky terminal-count flag (irq/irq_clr) built when CTR_SEQ_IRQ_EN is defined.
module ctr_sequencer
  import ctr_seq_pkg::*;
#(
  parameter int unsigned WIDTH        = 22,
  parameter int unsigned PRE_WIDTH    = 16,
  parameter int unsigned PRESCALE_DEF = 6
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic                                                  cmd_valid,
  output logic                                                  cmd_ready,
  input  logic [2:0]                                            cmd_op,
  input  logic [((PRE_WIDTH > WIDTH) ? PRE_WIDTH : WIDTH)-1:0]  cmd_data,
  output logic [WIDTH-1:0]                                      ctr_value,
  output logic                                                  tick,
  output logic                                                  wrap,
  output logic [1:0]                                            state,
  output logic                                                  cmd_err
`ifdef CTR_SEQ_IRQ_EN
  ,
  output logic                                                  irq,
  input  logic                                                  irq_clr
`endif
);

  ctr_state_t           cur_st, nxt_st;
  logic [WIDTH-1:0]     ctr_d, limit_q, limit_d;
  logic [PRE_WIDTH-1:0] pre_lim_q, pre_lim_d;
  logic                 auto_q, auto_d;
  logic                 wrap_d, err_d;
  logic                 tick_c, pre_clear_c;

  assign state = cur_st;

  ctr_seq_prescaler #(.PRE_WIDTH(PRE_WIDTH)) u_pre (
    .clk     (clk),
    .rst     (rst),
    .en      (cur_st == ST_RUN),
    .clear   (pre_clear_c),
    .pre_lim (pre_lim_q),
    .tick_c  (tick_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_st    <= ST_IDLE;
      ctr_value <= '0;
      limit_q   <= '1;
      pre_lim_q <= PRE_WIDTH'(PRESCALE_DEF);
      auto_q    <= 1'b0;
      tick      <= 1'b0;
      wrap      <= 1'b0;
      cmd_err   <= 1'b0;
      cmd_ready <= 1'b0;
    end else begin
      cur_st    <= nxt_st;
      ctr_value <= ctr_d;
      limit_q   <= limit_d;
      pre_lim_q <= pre_lim_d;
      auto_q    <= auto_d;
      tick      <= tick_c;
      wrap      <= wrap_d;
      cmd_err   <= err_d;
      cmd_ready <= 1'b1;
    end
  end

  // Tick handling first, then command effects; commands override where they collide.
  always_comb begin
    nxt_st      = cur_st;
    ctr_d       = ctr_value;
    limit_d     = limit_q;
    pre_lim_d   = pre_lim_q;
    auto_d      = auto_q;
    wrap_d      = 1'b0;
    err_d       = 1'b0;
    pre_clear_c = 1'b0;

    if (tick_c) begin
      if (ctr_value == limit_q) begin
        wrap_d = 1'b1;
        if (auto_q) ctr_d = '0;
        else        nxt_st = ST_DONE;
      end else begin
        ctr_d = ctr_value + WIDTH'(1);
      end
    end

    if (cmd_valid && cmd_ready) begin
      if (!op_legal(cur_st, cmd_op)) begin
        err_d = 1'b1;
      end else begin
        case (cmd_op)
          OP_SET_PRE: pre_lim_d = cmd_data[PRE_WIDTH-1:0];
          OP_SET_LIM: limit_d   = cmd_data[WIDTH-1:0];
          OP_START_ONE, OP_START_AUTO: begin
            ctr_d       = '0;
            auto_d      = (cmd_op == OP_START_AUTO);
            pre_clear_c = 1'b1;
            nxt_st      = ST_RUN;
          end
          // a one-shot run finishing on this same tick stays DONE
          OP_PAUSE:  if (nxt_st == ST_RUN) nxt_st = ST_PAUSED;
          OP_RESUME: nxt_st = ST_RUN;
          OP_ABORT: begin
            ctr_d       = '0;
            pre_clear_c = 1'b1;
            nxt_st      = ST_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef CTR_SEQ_IRQ_EN
  // Sticky flag follows the wrap pulse; a wrap seen with irq_clr keeps it set.
  always_ff @(posedge clk) begin
    if (rst) irq <= 1'b0;
    else     irq <= (irq && !irq_clr) || wrap;
  end
`endif

endmodule
